// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   start      request strobe, sampled only in IDLE
//   op[2:0]    funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   a, b       rs1 / rs2 operands
//   busy       high while an accepted operation iterates
//   done       one-cycle pulse, result valid
//   result     result of the last completed operation, held until the next
//   dbg_state  current FSM state (IDLE=0, MUL=1, DIV=2, DONE=3)
//
// Handshake: start is the request valid and "state==IDLE" is the implicit
// ready. A request is accepted on the rising edge where start=1 and the unit
// is IDLE; op/a/b are captured on that edge. Starts seen while busy or in
// DONE are dropped, not queued. Completion is signalled by done=1 for exactly
// one cycle, during which result already holds the new value.
//
// Multiplies and divides run on operand magnitudes and fix the sign at the
// end. Divide-by-zero and signed overflow skip the iteration entirely.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_main_q;   // negate product / quotient
  logic              neg_rem_q;    // negate remainder
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] prod_q;       // {partial high, multiplier bits not yet consumed}
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   quo_q;        // dividend bits shift out the top, quotient bits in at the bottom
  logic [XLEN-1:0]   dvsr_q;
  logic [XLEN-1:0]   result_q;

  // ---------------- operand preparation (from live inputs, used in IDLE)
  logic            a_sgn_en, b_sgn_en, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    a_sgn_en = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_sgn_en = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg    = a_sgn_en && a[XLEN-1];
    b_neg    = b_sgn_en && b[XLEN-1];
    // The most negative value negates to itself, which read as unsigned is
    // exactly its magnitude.
    a_mag    = a_neg ? (~a + 1'b1) : a;
    b_mag    = b_neg ? (~b + 1'b1) : b;

    div_zero = op[2] && (b == '0);
    div_ovf  = op[2] && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    fast     = div_zero || div_ovf;

    fast_res = '0;
    if (div_zero) begin
      fast_res = op[1] ? a : '1;
    end else if (div_ovf) begin
      fast_res = op[1] ? '0 : a;
    end
  end

  // ---------------- one shift-add multiply step
  logic [XLEN:0]     hi_sum;
  logic [2*XLEN-1:0] prod_step;
  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    hi_sum    = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_step = {hi_sum, prod_q[XLEN-1:1]};
    prod_fin  = neg_main_q ? (~prod_step + 1'b1) : prod_step;
    mul_res   = (op_q == 3'b000) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
  end

  // ---------------- one restoring divide step
  logic [XLEN:0]   shifted, trial;
  logic            sub_ok;
  logic [XLEN-1:0] rem_step, quo_step, quo_fin, rem_fin, div_res;

  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    trial    = shifted - {1'b0, dvsr_q};
    sub_ok   = !trial[XLEN];
    // On a failed subtract the shifted remainder is below the divisor, so its
    // top bit is zero and can be dropped.
    rem_step = sub_ok ? trial[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    quo_step = {quo_q[XLEN-2:0], sub_ok};
    quo_fin  = neg_main_q ? (~quo_step + 1'b1) : quo_step;
    rem_fin  = neg_rem_q  ? (~rem_step + 1'b1) : rem_step;
    div_res  = op_q[1] ? rem_fin : quo_fin;
  end

  logic last_iter;
  assign last_iter = (cnt_q == CW'(XLEN-1));

  // ---------------- FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (fast)       state_d = S_DONE;
          else if (op[2]) state_d = S_DIV;
          else            state_d = S_MUL;
        end
      end
      S_MUL:   if (last_iter) state_d = S_DONE;
      S_DIV:   if (last_iter) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      cnt_q      <= '0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      mcand_q    <= '0;
      prod_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      result_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q       <= op;
            cnt_q      <= '0;
            neg_main_q <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            mcand_q    <= a_mag;
            prod_q     <= {{XLEN{1'b0}}, b_mag};
            rem_q      <= '0;
            quo_q      <= a_mag;
            dvsr_q     <= b_mag;
            if (fast) result_q <= fast_res;
          end
        end
        S_MUL: begin
          prod_q <= prod_step;
          cnt_q  <= cnt_q + 1'b1;
          if (last_iter) result_q <= mul_res;
        end
        S_DIV: begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) result_q <= div_res;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule
